// File: rtl/ram_pkg.sv
// Shared types and helpers for the byte-writable synchronous RAM.
// Holds the controller state type, the lane-count helper and the byte merge.
package ram_pkg;

    // Controller states: sweeping zeros into the array, or serving traffic.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Upper bound on word width handled by the shared merge helper.
    // Package functions cannot be parameterised, so callers zero-pad
    // their words into this width and slice the result back down.
    localparam int MAX_DATA_BITS = 256;
    localparam int MAX_LANES     = 256;

    function automatic int calc_nbytes(input int data_bits,
                                       input int byte_bits);
        return data_bits / byte_bits;
    endfunction

    // Lane-wise select: each bit comes from new_word when its lane's
    // enable is set, otherwise it keeps the old_word value.
    function automatic logic [MAX_DATA_BITS-1:0] merge_bytes(
        input logic [MAX_DATA_BITS-1:0] old_word,
        input logic [MAX_DATA_BITS-1:0] new_word,
        input logic [MAX_LANES-1:0]     be,
        input int                       byte_bits
    );
        logic [MAX_DATA_BITS-1:0] merged;
        logic [7:0]               lane;
        logic [7:0]               bit_idx;
        merged = old_word;
        for (int j = 0; j < MAX_DATA_BITS; j++) begin
            lane    = 8'(j / byte_bits);
            bit_idx = 8'(j);
            if (be[lane]) begin
                merged[bit_idx] = new_word[bit_idx];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/ram_array.sv
// Raw storage for ram_bytewise_sync: one lane-masked write port and one
// combinational read port.
//   clock      : write clock
//   wen        : per-lane write enables (all zero = no write)
//   waddr      : write address
//   wdata      : write data
//   raddr      : read address
//   rdata      : combinational read data
module ram_array
    import ram_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16,
    parameter int BYTE_BITS = 8,
    parameter int NBYTES    = DATA_BITS / BYTE_BITS
) (
    input  logic                 clock,
    input  logic [NBYTES-1:0]    wen,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [DATA_BITS-1:0] wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [DATA_BITS-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [DATA_BITS-1:0] mem [DEPTH];

    logic [MAX_DATA_BITS-1:0] old_wide;
    logic [MAX_DATA_BITS-1:0] new_wide;
    logic [MAX_LANES-1:0]     wen_wide;
    logic [MAX_DATA_BITS-1:0] merged_wide;
    logic [DATA_BITS-1:0]     merged;

    // Read-modify-write of the addressed word keeps unselected lanes intact.
    always_comb begin
        old_wide                 = '0;
        new_wide                 = '0;
        wen_wide                 = '0;
        old_wide[DATA_BITS-1:0]  = mem[waddr];
        new_wide[DATA_BITS-1:0]  = wdata;
        wen_wide[NBYTES-1:0]     = wen;
        merged_wide = merge_bytes(old_wide, new_wide, wen_wide, BYTE_BITS);
        merged      = merged_wide[DATA_BITS-1:0];
    end

    always_ff @(posedge clock) begin
        if (|wen) begin
            mem[waddr] <= merged;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ram_bytewise_sync.sv
// Byte-writable single-clock RAM with registered read, valid strobe,
// optional write-first bypass and a zeroing sweep after reset/clear.
//   clock, reset_n    : clock and synchronous active-low reset
//   clear_req, ready  : start a zeroing sweep / memory is serving traffic
//   we, be, addr_write, data_write : lane-masked write port
//   re, addr_read     : read request
//   data_read, read_valid : registered read data and its one-cycle strobe
module ram_bytewise_sync
    import ram_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16,
    parameter int BYTE_BITS = 8,
    parameter int BYPASS    = 1,
    parameter int NBYTES    = calc_nbytes(DATA_BITS, BYTE_BITS)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 clear_req,
    output logic                 ready,
    input  logic                 we,
    input  logic [NBYTES-1:0]    be,
    input  logic [ADDR_BITS-1:0] addr_write,
    input  logic [DATA_BITS-1:0] data_write,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] addr_read,
    output logic [DATA_BITS-1:0] data_read,
    output logic                 read_valid
);

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;

    state_t               state;
    logic [ADDR_BITS-1:0] clear_addr;

    logic                 sweeping;
    logic                 user_write;
    logic                 user_read;

    logic [NBYTES-1:0]    arr_wen;
    logic [ADDR_BITS-1:0] arr_waddr;
    logic [DATA_BITS-1:0] arr_wdata;
    logic [DATA_BITS-1:0] arr_rdata;

    logic [MAX_DATA_BITS-1:0] old_wide;
    logic [MAX_DATA_BITS-1:0] new_wide;
    logic [MAX_LANES-1:0]     be_wide;
    logic [MAX_DATA_BITS-1:0] byp_wide;
    logic [DATA_BITS-1:0]     read_word;

    assign ready = (state == ST_READY);

    // A cycle held in reset performs no array write at all; a clear
    // request wins over any user access presented alongside it.
    assign sweeping   = reset_n && (state == ST_CLEAR);
    assign user_write = reset_n && ready && !clear_req && we;
    assign user_read  = reset_n && ready && !clear_req && re;

    always_comb begin
        arr_wen   = '0;
        arr_waddr = addr_write;
        arr_wdata = data_write;
        if (sweeping) begin
            arr_wen   = '1;
            arr_waddr = clear_addr;
            arr_wdata = '0;
        end else if (user_write) begin
            arr_wen   = be;
        end
    end

    ram_array #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (DATA_BITS),
        .BYTE_BITS (BYTE_BITS),
        .NBYTES    (NBYTES)
    ) u_array (
        .clock (clock),
        .wen   (arr_wen),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .raddr (addr_read),
        .rdata (arr_rdata)
    );

    // Write-first collision: present the word as it will look after
    // this cycle's write lands, without waiting for the array update.
    always_comb begin
        old_wide                = '0;
        new_wide                = '0;
        be_wide                 = '0;
        old_wide[DATA_BITS-1:0] = arr_rdata;
        new_wide[DATA_BITS-1:0] = data_write;
        be_wide[NBYTES-1:0]     = be;
        byp_wide  = merge_bytes(old_wide, new_wide, be_wide, BYTE_BITS);
        read_word = arr_rdata;
        if ((BYPASS != 0) && user_write && (addr_write == addr_read)) begin
            read_word = byp_wide[DATA_BITS-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= ST_CLEAR;
            clear_addr <= '0;
        end else begin
            unique case (state)
                ST_CLEAR: begin
                    clear_addr <= clear_addr + 1'b1;
                    if (clear_addr == LAST_ADDR) begin
                        state <= ST_READY;
                    end
                end
                ST_READY: begin
                    if (clear_req) begin
                        state      <= ST_CLEAR;
                        clear_addr <= '0;
                    end
                end
                default: begin
                    state      <= ST_CLEAR;
                    clear_addr <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            data_read  <= '0;
            read_valid <= 1'b0;
        end else begin
            read_valid <= user_read;
            if (user_read) begin
                data_read <= read_word;
            end
        end
    end

endmodule

// File: tb/tb_ram_bytewise_sync.sv
// Self-checking bench for ram_bytewise_sync: a write-first and a read-first
// instance share stimulus and are compared to a word-array reference model.
module tb_ram_bytewise_sync;

    localparam int DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        clear_req;
    logic        we;
    logic        re;
    logic [1:0]  be;
    logic [3:0]  addr_write;
    logic [3:0]  addr_read;
    logic [15:0] data_write;

    logic        rdy_f, rv_f, rdy_r, rv_r;
    logic [15:0] dr_f, dr_r;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] mdl_mem [DEPTH];
    int          mdl_left;
    logic        mdl_valid;
    logic [15:0] mdl_fwd;
    logic [15:0] mdl_rdf;

    always #5 clock = ~clock;

    ram_bytewise_sync #(
        .ADDR_BITS (4), .DATA_BITS (16), .BYTE_BITS (8), .BYPASS (1)
    ) u_fwd (
        .clock (clock), .reset_n (reset_n), .clear_req (clear_req),
        .ready (rdy_f), .we (we), .be (be), .addr_write (addr_write),
        .data_write (data_write), .re (re), .addr_read (addr_read),
        .data_read (dr_f), .read_valid (rv_f)
    );

    ram_bytewise_sync #(
        .ADDR_BITS (4), .DATA_BITS (16), .BYTE_BITS (8), .BYPASS (0)
    ) u_rdf (
        .clock (clock), .reset_n (reset_n), .clear_req (clear_req),
        .ready (rdy_r), .we (we), .be (be), .addr_write (addr_write),
        .data_write (data_write), .re (re), .addr_read (addr_read),
        .data_read (dr_r), .read_valid (rv_r)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lane_merge(input logic [15:0] o,
                                               input logic [15:0] n,
                                               input logic [1:0]  b);
        logic [15:0] r;
        r = o;
        if (b[0]) r[7:0]  = n[7:0];
        if (b[1]) r[15:8] = n[15:8];
        return r;
    endfunction

    task automatic zero_model();
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 16'h0000;
    endtask

    // One clock: update the model from the inputs seen at the edge,
    // then compare both instances just after the edge.
    task automatic step();
        logic [15:0] old;
        @(posedge clock);
        if (!reset_n) begin
            mdl_left  = DEPTH;
            zero_model();
            mdl_valid = 1'b0;
            mdl_fwd   = 16'h0000;
            mdl_rdf   = 16'h0000;
        end else if (mdl_left > 0) begin
            mdl_left--;
            mdl_valid = 1'b0;
        end else if (clear_req) begin
            mdl_left  = DEPTH;
            zero_model();
            mdl_valid = 1'b0;
        end else begin
            old = mdl_mem[addr_read];
            if (we) mdl_mem[addr_write] = lane_merge(mdl_mem[addr_write],
                                                     data_write, be);
            mdl_valid = re;
            if (re) begin
                mdl_fwd = mdl_mem[addr_read];
                mdl_rdf = old;
            end
        end
        #1;
        check("ready_f", 32'(rdy_f), 32'(mdl_left == 0));
        check("ready_r", 32'(rdy_r), 32'(mdl_left == 0));
        check("valid_f", 32'(rv_f), 32'(mdl_valid));
        check("valid_r", 32'(rv_r), 32'(mdl_valid));
        check("data_f", 32'(dr_f), 32'(mdl_fwd));
        check("data_r", 32'(dr_r), 32'(mdl_rdf));
    endtask

    task automatic idle();
        clear_req = 1'b0;
        we        = 1'b0;
        re        = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d,
                      input logic [1:0] b);
        idle();
        we = 1'b1; addr_write = a; data_write = d; be = b;
    endtask

    task automatic rd(input logic [3:0] a);
        idle();
        re = 1'b1; addr_read = a;
    endtask

    initial begin
        int run;
        reset_n    = 1'b0;
        be         = 2'b00;
        addr_write = 4'h0;
        addr_read  = 4'h0;
        data_write = 16'h0000;
        idle();
        step();
        step();
        check("rst_data", 32'(dr_f), 32'h0);
        reset_n = 1'b1;

        // Power-up sweep; stray reads must not strobe.
        for (int i = 0; i < DEPTH; i++) begin
            idle();
            re        = 1'($urandom);
            addr_read = 4'($urandom);
            step();
            if (i == DEPTH - 2) check("sweep_lo", 32'(rdy_f), 32'h0);
        end
        check("sweep_hi", 32'(rdy_f), 32'h1);
        for (int i = 0; i < DEPTH; i++) begin
            rd(4'(i));
            step();
        end

        // Partial-lane overwrite.
        wr(4'd3, 16'hA5C3, 2'b11); step();
        wr(4'd3, 16'h1234, 2'b01); step();
        rd(4'd3); step();
        check("merge3", 32'(dr_f), 32'hA534);

        // Same-address collision on a zeroed word.
        wr(4'd5, 16'hBEEF, 2'b10);
        re = 1'b1; addr_read = 4'd5;
        step();
        check("coll_fwd", 32'(dr_f), 32'hBE00);
        check("coll_rdf", 32'(dr_r), 32'h0000);
        rd(4'd5); step();
        check("coll_after", 32'(dr_r), 32'hBE00);

        // Clear request drops a simultaneous write.
        for (int i = 0; i < DEPTH; i++) begin
            wr(4'(i), 16'(i), 2'b11); step();
        end
        wr(4'd2, 16'hFFFF, 2'b11);
        clear_req = 1'b1;
        step();
        check("clr_drop", 32'(rdy_f), 32'h0);
        idle();
        for (int i = 0; i < DEPTH; i++) step();
        for (int i = 0; i < DEPTH; i++) begin
            rd(4'(i)); step();
        end

        // Reset in the middle of a sweep restarts it.
        idle(); clear_req = 1'b1; step();
        idle();
        for (int i = 0; i < 7; i++) step();
        reset_n = 1'b0; step();
        reset_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            idle();
            re        = 1'b1;
            addr_read = 4'($urandom);
            step();
            if (i == DEPTH - 2) check("rst_sweep_lo", 32'(rdy_f), 32'h0);
        end
        check("rst_sweep_hi", 32'(rdy_f), 32'h1);

        // Back-to-back streaming reads.
        for (int i = 0; i < DEPTH; i++) begin
            wr(4'(i), 16'h0100 + 16'(i), 2'b11); step();
        end
        run = 0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rd(4'(i)); step();
            if (rv_f) run++;
        end
        check("stream_run", 32'(run), 32'(DEPTH));
        check("stream_last", 32'(dr_f), 32'h0100);

        // Random traffic with frequent collisions.
        for (int i = 0; i < 400; i++) begin
            reset_n    = 1'($urandom_range(0, 99) != 0);
            clear_req  = 1'($urandom_range(0, 59) == 0);
            we         = 1'($urandom);
            re         = 1'($urandom);
            be         = 2'($urandom);
            addr_write = 4'($urandom);
            addr_read  = $urandom_range(0, 1) ? addr_write : 4'($urandom);
            data_write = 16'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_bytewise_sync.md
# ram_bytewise_sync

Parametrised single-clock, one-write/one-read memory with per-byte write enables, a registered read port with a valid strobe, and a built-in clear engine. On reset or on request it zeroes every location, one word per cycle. It is the next-generation data/register-file store for the processor. Unlike the plain asynchronous-read array, it offers configurable width and depth, read-during-write control, and a guaranteed-known power-up content.

## Interface
Parameters:
- ADDR_BITS, default `ADDR_BITS` (8): address width; depth = 2**ADDR_BITS.
- DATA_BITS, default `DATA_BITS` (16): word width; must be a multiple of BYTE_BITS.
- BYTE_BITS, default 8: lane width; NBYTES = DATA_BITS/BYTE_BITS.
- BYPASS, default 1: 1 = write-first on a same-address collision, 0 = read-first.

Ports:
- clock, in, 1: single clock; all state updates on its rising edge.
- reset_n, in, 1: synchronous, active-low reset.
- clear_req, in, 1: starts a full zeroing sweep (honoured only while ready=1).
- ready, out, 1: high when the memory accepts reads and writes.
- we, in, 1: write request.
- be, in, NBYTES: byte-lane enables for the write.
- addr_write, in, ADDR_BITS: write address.
- data_write, in, DATA_BITS: write data.
- re, in, 1: read request.
- addr_read, in, ADDR_BITS: read address.
- data_read, out, DATA_BITS: registered read data.
- read_valid, out, 1: one-cycle pulse marking new data_read.

## Operation
- States: CLEAR and READY.
- Reset (reset_n=0 at an edge):
  - state→CLEAR, clear_addr→0.
  - ready=0, read_valid=0, data_read=0.
  - Array contents are not directly reset.
- CLEAR:
  - Each edge with reset_n=1 writes all-zero to mem[clear_addr] and increments clear_addr.
  - On the edge that writes address 2**ADDR_BITS−1, state→READY and ready→1.
  - we, re and clear_req are ignored; no read_valid is produced.
- READY, write: when we=1, lane i of mem[addr_write] takes data_write lane i only where be[i]=1; other lanes are unchanged. we=1 with be=0 is a no-op.
- READY, read: when re=1, data_read is loaded with mem[addr_read] and read_valid=1 on the next cycle. When re=0, data_read holds its value and read_valid=0.
- Collision (we=re=1, addr_write==addr_read):
  - BYPASS=1: data_read is the post-write word (new data in enabled lanes, old data elsewhere).
  - BYPASS=0: data_read is the pre-write word.
- clear_req=1 in READY has priority: any write or read in that same cycle is dropped, state→CLEAR, clear_addr→0.
- Reset during CLEAR restarts the sweep at address 0.
- Addresses wrap naturally: clear_addr is ADDR_BITS wide, and the terminal compare uses the all-ones value.

## Timing
- Read latency: exactly 1 cycle (request at edge N, data and read_valid visible after edge N; read_valid pulse width 1).
- Full throughput: one read and one write per cycle, back-to-back.
- Sweep length: 2**ADDR_BITS cycles after the last reset or accepted clear_req edge. ready rises after the edge that writes the last address.
- ready falls on the edge that accepts clear_req.
- Outputs after reset: ready=0, read_valid=0, data_read=0.

## Structure
- Shared package ram_pkg holds:
  - The state enum (CLEAR, READY).
  - A localparam-style function computing NBYTES.
  - A byte-merge function (old word, new word, be) → merged word, used by both the write path and the bypass path.
- Sub-module ram_array: the raw storage, with a single write port (per-lane enable) and a combinational read. The top level owns the FSM, the clear counter, the write mux (clear vs user), the read register, and the bypass.

## Test plan
Bench parameters: ADDR_BITS=4, DATA_BITS=16, BYTE_BITS=8.
- Reset release → ready=0 for 16 cycles, then 1. Reading all 16 addresses afterwards returns 0x0000, each with read_valid one cycle after re.
- Write 0xA5C3 to addr 3 with be=11, then write 0x1234 to addr 3 with be=01, then read addr 3 → data_read=0xA534.
- BYPASS=1: with mem[5]=0x0000, drive we=re=1, addr 5, data 0xBEEF, be=10 in the same cycle → data_read=0xBE00 next cycle. BYPASS=0 → 0x0000, and a following read returns 0xBE00.
- Fill addresses 0–15 with their index, then pulse clear_req while we=1 (addr 2, data 0xFFFF) → the write is dropped and ready=0 for 16 cycles. Every later read returns 0x0000.
- Assert reset_n=0 for one cycle at sweep cycle 7 → the sweep restarts and ready rises exactly 16 cycles after reset release. re pulses during CLEAR produce no read_valid.
- Streaming: 16 consecutive reads of addrs 15…0 after writes of 0x0100+addr → read_valid high for 16 consecutive cycles with matching data.
